// File: rtl/key_req_latch8_pkg.sv
// Shared constants and helpers for the key request latch front-end.
package key_req_latch8_pkg;

  localparam int unsigned N_LINES   = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned CNT_OUT_W = 4;
  localparam logic [N_LINES:1] IDLE_BUS = 8'hFF;

  typedef logic [N_LINES:1] line_vec_t;

  function automatic logic [CNT_OUT_W-1:0] popcount(input line_vec_t v);
    logic [CNT_OUT_W-1:0] s;
    s = '0;
    for (int unsigned i = 1; i <= N_LINES; i++) begin
      s = s + CNT_OUT_W'(v[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/key_req_latch8_if.sv
// Request/acknowledge bus between the raw key lines, the latch and its consumer.
interface key_req_latch8_if;
  import key_req_latch8_pkg::*;

  logic [N_LINES:1]   raw_n;
  logic               ack_valid;
  logic [IDX_W-1:0]   ack_idx;
  logic [N_LINES:1]   w;
  logic [CNT_OUT_W-1:0] pend_cnt;
  logic               dup_pulse;

  modport master (
    output raw_n, ack_valid, ack_idx,
    input  w, pend_cnt, dup_pulse
  );

  modport slave (
    input  raw_n, ack_valid, ack_idx,
    output w, pend_cnt, dup_pulse
  );

endinterface

// File: rtl/key_req_latch8_debounce_cell.sv
// One request line: 2-flop synchroniser, debounce counter and stable level.
module key_req_latch8_debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n_bit,
  output logic stable,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_accept;

  assign w_differ = (r_sync2 != r_stable);
  assign w_accept = w_differ && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= raw_n_bit;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Press is flagged on the very edge that moves stable from 1 to 0.
  assign press  = w_accept && !r_sync2;
  assign stable = r_stable;

endmodule

// File: rtl/key_req_latch8.sv
// Debounces 8 active-low request lines and holds each press pending until acknowledged.
module key_req_latch8
  import key_req_latch8_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input logic             clk,
  input logic             rst_n,
  key_req_latch8_if.slave bus
);

  line_vec_t w_press;
  line_vec_t w_stable;
  line_vec_t w_ack_hit;
  line_vec_t r_pend;
  logic      r_dup;

  for (genvar g = 1; g <= N_LINES; g++) begin : g_line
    key_req_latch8_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_n_bit(bus.raw_n[g]),
      .stable   (w_stable[g]),
      .press    (w_press[g])
    );
  end

  always_comb begin
    w_ack_hit = '0;
    for (int unsigned i = 1; i <= N_LINES; i++) begin
      w_ack_hit[i] = bus.ack_valid && (bus.ack_idx == IDX_W'(i - 1));
    end
  end

  // Set beats clear; a press on a line being acked this cycle is not a duplicate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_dup  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_ack_hit) | w_press;
      r_dup  <= |(w_press & r_pend & ~w_ack_hit);
    end
  end

  assign bus.w         = ~r_pend;
  assign bus.pend_cnt  = popcount(r_pend);
  assign bus.dup_pulse = r_dup;

  a_press_from_released : assert property (
    @(posedge clk) disable iff (!rst_n) (w_press & ~w_stable) == '0
  );

endmodule
